// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480 raster timing, sync generation and palette decode.
// RGB, hsync and vsync leave the block aligned, one pixel behind pixel_x/y.
module vga_scan_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  color_code,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        video_on,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] rgb
);

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]  div_q, div_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        tick;
  logic        vis;
  logic [23:0] pal;

  assign tick = (div_q == DIV_LAST);
  assign vis  = (x_q < H_VIS) && (y_q < V_VIS);

  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (!tick) begin
      div_d = div_q + 4'd1;
    end else begin
      div_d = '0;
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_comb begin
    pal = 24'h000000;
    unique case (color_code)
      3'd0: pal = 24'h000000;
      3'd1: pal = 24'h00FF00;
      3'd2: pal = 24'h0000FF;
      3'd3: pal = 24'hFF0000;
      3'd4: pal = 24'h66FFFF;
      3'd5: pal = 24'hD3D3D3;
      3'd6: pal = 24'hFFFFFF;
      3'd7: pal = 24'hCCFF99;
      default: pal = 24'h000000;
    endcase
  end

  // Output stage samples the pre-increment counters, giving the one-pixel lag.
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (tick) begin
      rgb_d = vis ? pal : 24'h000000;
      hs_d  = ~((x_q >= HS_BEG) && (x_q < HS_END));
      vs_d  = ~((y_q >= VS_BEG) && (y_q < VS_END));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign video_on    = vis;
  assign pix_tick    = tick;
  assign frame_start = tick && !rst && (x_q == '0) && (y_q == '0);
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: scoreboard bench for vga_scan_gen.
// dut0 uses the default timing; dut1 is a tiny raster so whole frames fit.
module tb_vga_scan_gen;

  localparam int SX = 0;
  localparam int SY = 1;
  localparam int SH = 2;
  localparam int SV = 3;
  localparam int SR = 4;
  localparam int ST = 5;
  localparam int SF = 6;

  typedef struct {
    int unsigned t;
    int          dut;
    int          sig;
    logic [23:0] exp;
  } chk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [2:0]  cc0, cc1;
  logic [15:0] x0, y0, x1, y1;
  logic        von0, von1, tk0, tk1, fs0, fs1;
  logic        hs0, hs1, vs0, vs1;
  logic [23:0] rgb0, rgb1;

  assign cc0 = x0[2:0];
  assign cc1 = 3'd6;

  vga_scan_gen dut0 (
    .clk(clk), .rst(rst), .color_code(cc0),
    .pixel_x(x0), .pixel_y(y0), .video_on(von0),
    .pix_tick(tk0), .frame_start(fs0),
    .hsync(hs0), .vsync(vs0), .rgb(rgb0)
  );

  vga_scan_gen #(
    .CLK_DIV(1),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut1 (
    .clk(clk), .rst(rst), .color_code(cc1),
    .pixel_x(x1), .pixel_y(y1), .video_on(von1),
    .pix_tick(tk1), .frame_start(fs1),
    .hsync(hs1), .vsync(vs1), .rgb(rgb1)
  );

  chk_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned t = 0;
  logic        tmo = 1'b0;
  logic        tmo_seen = 1'b0;
  string       nm[7] = '{"pixel_x", "pixel_y", "hsync", "vsync",
                         "rgb", "pix_tick", "frame_start"};
  logic [23:0] pal[8] = '{24'h000000, 24'h00FF00, 24'h0000FF,
                          24'hFF0000, 24'h66FFFF, 24'hD3D3D3,
                          24'hFFFFFF, 24'hCCFF99};

  task automatic push(int unsigned tt, int d, int s, logic [23:0] e);
    chk_t c;
    c.t = tt; c.dut = d; c.sig = s; c.exp = e;
    sb.push_back(c);
  endtask

  function automatic logic [23:0] act(int d, int s);
    logic [15:0] x, y;
    logic        h, v, k, f;
    logic [23:0] r;
    if (d == 0) begin
      x = x0; y = y0; h = hs0; v = vs0; k = tk0; f = fs0; r = rgb0;
    end else begin
      x = x1; y = y1; h = hs1; v = vs1; k = tk1; f = fs1; r = rgb1;
    end
    case (s)
      SX: return {8'd0, x};
      SY: return {8'd0, y};
      SH: return {23'd0, h};
      SV: return {23'd0, v};
      SR: return r;
      ST: return {23'd0, k};
      default: return {23'd0, f};
    endcase
  endfunction

  // t counts clk edges since reset was last released
  always @(posedge clk) t <= rst ? 0 : t + 1;

  always @(negedge clk) begin
    logic [23:0] a;
    if (!rst) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].t == t) begin
          n_tests++;
          a = act(sb[i].dut, sb[i].sig);
          if (a !== sb[i].exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0d got %h want %h",
                     nm[sb[i].sig], sb[i].dut, t, a, sb[i].exp);
          end
          sb.delete(i);
        end else if (sb[i].t < t) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s dut%0d missed t=%0d now %0d",
                   nm[sb[i].sig], sb[i].dut, sb[i].t, t);
          sb.delete(i);
        end
      end
    end
    if (tmo && !tmo_seen) begin
      tmo_seen <= 1'b1;
      n_tests++;
      n_fail++;
      $display("FAIL timeout got pending=%0d want 0", sb.size());
    end
  end

  task automatic push_phase_a();
    push(0, 0, SX, 0); push(0, 0, SY, 0); push(0, 0, SH, 1);
    push(0, 0, SV, 1); push(0, 0, SR, 0); push(0, 0, ST, 0);
    push(0, 0, SF, 0);
    push(1, 0, ST, 1); push(1, 0, SF, 1); push(1, 0, SX, 0);
    push(2, 0, SX, 1); push(2, 0, ST, 0);
    push(3, 0, ST, 1); push(3, 0, SF, 0);
    for (int i = 0; i < 8; i++) push(2 * i + 2, 0, SR, pal[i]);
    push(1280, 0, SR, 24'hCCFF99);
    push(1292, 0, SR, 0);
    push(1312, 0, SH, 1); push(1314, 0, SH, 0);
    push(1505, 0, SH, 0); push(1506, 0, SH, 1);
    push(1598, 0, SX, 799); push(1598, 0, SY, 0);
    push(1599, 0, SX, 799); push(1599, 0, ST, 1);
    push(1600, 0, SX, 0); push(1600, 0, SY, 1);
    push(1604, 0, SR, 24'h00FF00);
    push(16012, 0, SR, 24'hD3D3D3); push(16013, 0, SR, 24'hD3D3D3);
    push(16014, 0, SR, 24'hFFFFFF); push(16012, 0, SV, 1);
    push(17400, 0, SH, 0); push(17400, 0, SX, 700);
    push(17400, 0, SY, 10);
    push(0, 1, ST, 1); push(0, 1, SF, 1); push(0, 1, SX, 0);
    push(0, 1, SY, 0); push(0, 1, SH, 1); push(0, 1, SV, 1);
    push(0, 1, SR, 0);
    push(1, 1, SR, 24'hFFFFFF); push(1, 1, SF, 0); push(1, 1, SX, 1);
    push(8, 1, SR, 24'hFFFFFF); push(9, 1, SR, 0);
    push(10, 1, SH, 1); push(11, 1, SH, 0);
    push(13, 1, SH, 0); push(14, 1, SH, 1);
    push(15, 1, SX, 15); push(15, 1, SY, 0);
    push(16, 1, SX, 0); push(16, 1, SY, 1); push(16, 1, SR, 0);
    push(17, 1, SR, 24'hFFFFFF);
    push(88, 1, SR, 24'hFFFFFF); push(96, 1, SR, 0); push(97, 1, SR, 0);
    push(128, 1, SV, 1); push(129, 1, SV, 0);
    push(160, 1, SV, 0); push(161, 1, SV, 1);
    push(191, 1, SX, 15); push(191, 1, SY, 11); push(191, 1, SF, 0);
    push(192, 1, SX, 0); push(192, 1, SY, 0); push(192, 1, SF, 1);
    push(193, 1, SF, 0);
  endtask

  task automatic push_phase_b();
    push(0, 0, SX, 0); push(0, 0, SY, 0); push(0, 0, SH, 1);
    push(0, 0, SV, 1); push(0, 0, SR, 0); push(0, 0, ST, 0);
    push(0, 0, SF, 0);
    push(1, 0, ST, 1); push(1, 0, SF, 1);
    push(2, 0, SX, 1); push(4, 0, SR, 24'h00FF00);
    push(0, 1, SX, 0); push(0, 1, SY, 0); push(0, 1, SR, 0);
    push(0, 1, SF, 1); push(0, 1, SH, 1);
    push(1, 1, SR, 24'hFFFFFF);
    push(192, 1, SF, 1); push(383, 1, SF, 0); push(384, 1, SF, 1);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    push_phase_a();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40000 && !found; i++) begin
      @(negedge clk);
      if (x0 == 16'd700 && y0 == 16'd10) found = 1'b1;
    end
    if (!found) tmo = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    push_phase_b();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) tmo = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
